// File: rtl/param_accumulator.sv
// Parameterised accumulator with load/add/inc/dec commands, wrap or clamp overflow handling,
// and an auto-count mode that steps op up to a sampled limit.
module param_accumulator #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             add,
  input  logic             inc,
  input  logic             dec,
  input  logic             start,
  input  logic [WIDTH-1:0] ip,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] op,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic {StIdle, StCount} state_e;

  localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0] sum_add, sum_inc, diff_dec;

  assign sum_add  = {1'b0, op_q} + {1'b0, ip};
  assign sum_inc  = {1'b0, op_q} + StepExt;
  assign diff_dec = {1'b0, op_q} - StepExt;

  // Bit WIDTH flags carry (up) or borrow (down); clamp picks the rail in that direction.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH:0] r, input logic up);
    if (r[WIDTH] && SATURATE) begin
      resolve = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else begin
      resolve = r[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          op_d  = '0;
          ovf_d = 1'b0;
        end else if (ld) begin
          op_d = ip;
        end else if (add) begin
          op_d  = resolve(sum_add, 1'b1);
          ovf_d = ovf_q | sum_add[WIDTH];
        end else if (inc || dec) begin
          // inc and dec together cancel: hold op and ovf
          if (!dec) begin
            op_d  = resolve(sum_inc, 1'b1);
            ovf_d = ovf_q | sum_inc[WIDTH];
          end else if (!inc) begin
            op_d  = resolve(diff_dec, 1'b0);
            ovf_d = ovf_q | diff_dec[WIDTH];
          end
        end else if (start) begin
          if (op_q < limit) begin
            limit_d = limit;
            state_d = StCount;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StCount: begin
        if (clr) begin
          op_d    = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else if (ld) begin
          op_d    = ip;
          state_d = StIdle;
        end else if (sum_inc >= {1'b0, limit_q}) begin
          op_d    = limit_q;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          op_d = sum_inc[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      limit_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      limit_q <= limit_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign op   = op_q;
  assign ovf  = ovf_q;
  assign done = done_q;
  assign busy = (state_q == StCount);

endmodule

// File: tb/tb_param_accumulator.sv
// Bench for param_accumulator: three instances (wrap/step 1, clamp/step 1, wrap/step 4) driven in
// parallel, each checked against a behavioural model through an expected-value queue.
module tb_param_accumulator;

  typedef struct packed {
    logic [7:0] op;
    logic       ovf;
    logic       busy;
    logic       done;
    logic [7:0] lim;
  } mst_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, add = 1'b0, inc = 1'b0, dec = 1'b0, start = 1'b0;
  logic [7:0] ip = '0, limit = '0;

  logic [7:0] op_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       ovf_w [3];

  int unsigned steps [3] = '{1, 1, 4};
  bit          sats [3]  = '{1'b0, 1'b1, 1'b0};
  mst_t        m [3];
  mst_t        exp_q [3][$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  param_accumulator #(.WIDTH(8), .STEP(1), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .rst_n(rst_n), .clr(clr), .ld(ld), .add(add), .inc(inc), .dec(dec),
    .start(start), .ip(ip), .limit(limit), .op(op_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .ovf(ovf_w[0])
  );

  param_accumulator #(.WIDTH(8), .STEP(1), .SATURATE(1'b1)) u_sat (
    .clock(clock), .rst_n(rst_n), .clr(clr), .ld(ld), .add(add), .inc(inc), .dec(dec),
    .start(start), .ip(ip), .limit(limit), .op(op_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .ovf(ovf_w[1])
  );

  param_accumulator #(.WIDTH(8), .STEP(4), .SATURATE(1'b0)) u_step4 (
    .clock(clock), .rst_n(rst_n), .clr(clr), .ld(ld), .add(add), .inc(inc), .dec(dec),
    .start(start), .ip(ip), .limit(limit), .op(op_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .ovf(ovf_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic mst_t resolve(input mst_t s, input int t, input bit sat);
    mst_t n;
    n = s;
    if (t > 255) begin
      n.ovf = 1'b1;
      n.op  = sat ? 8'hFF : 8'(t - 256);
    end else if (t < 0) begin
      n.ovf = 1'b1;
      n.op  = sat ? 8'h00 : 8'(t + 256);
    end else begin
      n.op = 8'(t);
    end
    return n;
  endfunction

  function automatic mst_t model(input mst_t s, input logic c, l, a, i, d, st,
                                 input logic [7:0] ipv, limv, input int unsigned step,
                                 input bit sat);
    mst_t n;
    int   t;
    n = s;
    n.done = 1'b0;
    if (!s.busy) begin
      if (c) begin
        n.op  = 8'h00;
        n.ovf = 1'b0;
      end else if (l) begin
        n.op = ipv;
      end else if (a) begin
        n = resolve(n, int'(s.op) + int'(ipv), sat);
      end else if (i && d) begin
        n = s;
        n.done = 1'b0;
      end else if (i) begin
        n = resolve(n, int'(s.op) + int'(step), sat);
      end else if (d) begin
        n = resolve(n, int'(s.op) - int'(step), sat);
      end else if (st) begin
        if (s.op < limv) begin
          n.busy = 1'b1;
          n.lim  = limv;
        end else begin
          n.done = 1'b1;
        end
      end
    end else begin
      if (c) begin
        n.op   = 8'h00;
        n.ovf  = 1'b0;
        n.busy = 1'b0;
      end else if (l) begin
        n.op   = ipv;
        n.busy = 1'b0;
      end else begin
        t = int'(s.op) + int'(step);
        if (t >= int'(s.lim)) begin
          n.op   = s.lim;
          n.busy = 1'b0;
          n.done = 1'b1;
        end else begin
          n.op = 8'(t);
        end
      end
    end
    return n;
  endfunction

  task automatic cmp(input int k, input mst_t e);
    check($sformatf("dut%0d op", k), {24'b0, op_w[k]}, {24'b0, e.op});
    check($sformatf("dut%0d ovf", k), {31'b0, ovf_w[k]}, {31'b0, e.ovf});
    check($sformatf("dut%0d busy", k), {31'b0, busy_w[k]}, {31'b0, e.busy});
    check($sformatf("dut%0d done", k), {31'b0, done_w[k]}, {31'b0, e.done});
  endtask

  task automatic cyc(input logic c, l, a, i, d, s, input logic [7:0] ipv, limv);
    @(negedge clock);
    clr = c; ld = l; add = a; inc = i; dec = d; start = s; ip = ipv; limit = limv;
    for (int k = 0; k < 3; k++) begin
      m[k] = model(m[k], c, l, a, i, d, s, ipv, limv, steps[k], sats[k]);
      exp_q[k].push_back(m[k]);
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() == 0) begin
        check($sformatf("dut%0d scoreboard empty", k), 32'd0, 32'd1);
      end else begin
        cmp(k, exp_q[k].pop_front());
      end
    end
  endtask

  task automatic hold(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s dut%0d op", tag, k), {24'b0, op_w[k]}, 32'd0);
      check($sformatf("%s dut%0d flags", tag, k), {29'b0, ovf_w[k], busy_w[k], done_w[k]}, 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m[k] = '0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // Wrap on increment past 0xFF, then clear
    cyc(0, 1, 0, 0, 0, 0, 8'hFE, 8'h00);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    check("wrap inc1 op", {24'b0, op_w[0]}, 32'hFF);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    check("wrap inc2 op", {24'b0, op_w[0]}, 32'h00);
    check("wrap inc2 ovf", {31'b0, ovf_w[0]}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("wrap clr ovf", {31'b0, ovf_w[0]}, 32'd0);

    // Clamp on borrow and on carry; ld must not clear ovf
    cyc(0, 1, 0, 0, 0, 0, 8'h02, 8'h00);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    check("sat dec3 op", {24'b0, op_w[1]}, 32'h00);
    check("sat dec3 ovf", {31'b0, ovf_w[1]}, 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 8'h10, 8'h00);
    check("sat ld keeps ovf", {31'b0, ovf_w[1]}, 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
    check("sat add op", {24'b0, op_w[1]}, 32'hFF);

    // inc and dec together hold
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 8'h33, 8'h00);
    cyc(0, 0, 0, 1, 1, 0, 8'h00, 8'h00);
    check("inc+dec hold", {24'b0, op_w[0]}, 32'h33);

    // Auto-count to 3 with distractions that COUNT must ignore
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h03);
    check("cnt3 busy k", {31'b0, busy_w[0]}, 32'd1);
    check("cnt3 op k", {24'b0, op_w[0]}, 32'd0);
    cyc(0, 0, 1, 0, 0, 1, 8'h40, 8'hFF);
    check("cnt3 op k+1", {24'b0, op_w[0]}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'hFF);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    check("cnt3 op k+3", {24'b0, op_w[0]}, 32'd3);
    check("cnt3 done k+3", {31'b0, done_w[0]}, 32'd1);
    check("cnt3 busy k+3", {31'b0, busy_w[0]}, 32'd0);
    hold(1);
    check("cnt3 done k+4", {31'b0, done_w[0]}, 32'd0);

    // Step 4 to limit 10, then a start that is already at/above its limit
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'd10);
    hold(3);
    check("step4 op", {24'b0, op_w[2]}, 32'd10);
    check("step4 done", {31'b0, done_w[2]}, 32'd1);
    check("step4 ovf", {31'b0, ovf_w[2]}, 32'd0);
    hold(8);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'd5);
    check("start ge done", {31'b0, done_w[2]}, 32'd1);
    check("start ge op", {24'b0, op_w[2]}, 32'd10);
    check("start ge busy", {31'b0, busy_w[2]}, 32'd0);

    // ld aborts a running count without done
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'hF0);
    hold(2);
    cyc(0, 1, 0, 0, 0, 0, 8'h55, 8'h00);
    check("abort ld op", {24'b0, op_w[0]}, 32'h55);
    check("abort ld busy", {31'b0, busy_w[0]}, 32'd0);
    check("abort ld done", {31'b0, done_w[0]}, 32'd0);
    hold(1);

    // Asynchronous reset in the middle of a count
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'hF0);
    hold(2);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async rst");
    @(posedge clock);
    #1 check_all_zero("rst held");
    for (int k = 0; k < 3; k++) m[k] = '0;
    @(negedge clock);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 8'h7A, 8'h00);
    check("first edge after rst", {24'b0, op_w[0]}, 32'h7A);

    // Random mix against the model
    for (int j = 0; j < 400; j++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
